// File: rtl/ecc_enc_dec.sv
// APB-programmed extended-Hamming (SECDED) encoder/decoder for 8/16/32-bit codewords.
// A CTRL write queues one operation; its result lands one clock later with a done pulse.
module ecc_enc_dec #(
  parameter int unsigned AMBA_WORD       = 32,
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PENABLE,
  input  logic                       PSEL,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       operation_done,
  output logic [1:0]                 num_of_errors
);

  typedef enum logic [1:0] {
    OP_ENCODE = 2'd0,
    OP_DECODE = 2'd1,
    OP_FULL   = 2'd2,
    OP_NOP    = 2'd3
  } op_e;

  typedef struct packed {
    logic [1:0]  nerr;
    logic [25:0] data;
  } dec_t;

  localparam logic [AMBA_ADDR_WIDTH-1:0] A_CTRL  = AMBA_ADDR_WIDTH'(32'h00);
  localparam logic [AMBA_ADDR_WIDTH-1:0] A_DATA  = AMBA_ADDR_WIDTH'(32'h04);
  localparam logic [AMBA_ADDR_WIDTH-1:0] A_WIDTH = AMBA_ADDR_WIDTH'(32'h08);
  localparam logic [AMBA_ADDR_WIDTH-1:0] A_NOISE = AMBA_ADDR_WIDTH'(32'h0C);

  // Parity column for data bit i is the i-th non-power-of-two >= 3.
  function automatic logic [4:0] parity_bits(input logic [25:0] d, input int unsigned k);
    logic [4:0]  p;
    int unsigned idx;
    p   = '0;
    idx = 0;
    for (int unsigned h = 3; h < 32; h++) begin
      if ((h & (h - 1)) != 0) begin
        if (idx < k && d[5'(idx)]) p = p ^ 5'(h);
        idx++;
      end
    end
    return p;
  endfunction

  function automatic logic [31:0] encode_cw(input logic [25:0] d, input int unsigned k,
                                            input int unsigned m);
    logic [31:0] cw;
    logic [4:0]  p;
    cw = '0;
    p  = parity_bits(d, k);
    for (int unsigned i = 0; i < 26; i++) if (i < k) cw[5'(i)] = d[5'(i)];
    for (int unsigned j = 0; j < 5; j++) if (j < m) cw[5'(k + j)] = p[3'(j)];
    cw[5'(k + m)] = ^cw;
    return cw;
  endfunction

  function automatic dec_t decode_cw(input logic [31:0] r, input int unsigned k,
                                     input int unsigned m);
    dec_t        res;
    logic [25:0] d;
    logic [4:0]  p;
    logic [4:0]  s;
    logic        q;
    logic        hit;
    int unsigned idx;
    d   = '0;
    s   = '0;
    q   = 1'b0;
    hit = 1'b0;
    idx = 0;
    for (int unsigned i = 0; i < 26; i++) if (i < k) d[5'(i)] = r[5'(i)];
    p = parity_bits(d, k);
    for (int unsigned j = 0; j < 5; j++) if (j < m) s[3'(j)] = r[5'(k + j)] ^ p[3'(j)];
    for (int unsigned i = 0; i < 32; i++) if (i <= k + m) q = q ^ r[5'(i)];
    res.data = d;
    res.nerr = 2'd0;
    if (q) begin
      // Zero or single-bit syndrome: the flipped bit is a check bit, data is intact.
      if ((s & (s - 5'd1)) == '0) begin
        res.nerr = 2'd1;
      end else begin
        for (int unsigned h = 3; h < 32; h++) begin
          if ((h & (h - 1)) != 0) begin
            if (idx < k && s == 5'(h)) begin
              res.data[5'(idx)] = ~d[5'(idx)];
              hit = 1'b1;
            end
            idx++;
          end
        end
        res.nerr = hit ? 2'd1 : 2'd2;
      end
    end else if (s != '0) begin
      res.nerr = 2'd2;
    end
    return res;
  endfunction

  function automatic logic [31:0] encode_w(input logic [25:0] d, input logic [1:0] w);
    logic [31:0] cw;
    case (w)
      2'd0:    cw = encode_cw(d, 4, 3);
      2'd1:    cw = encode_cw(d, 11, 4);
      default: cw = encode_cw(d, 26, 5);
    endcase
    return cw;
  endfunction

  function automatic dec_t decode_w(input logic [31:0] r, input logic [1:0] w);
    dec_t res;
    case (w)
      2'd0:    res = decode_cw(r, 4, 3);
      2'd1:    res = decode_cw(r, 11, 4);
      default: res = decode_cw(r, 26, 5);
    endcase
    return res;
  endfunction

  op_e                   ctrl_q, ctrl_d;
  op_e                   op_q, op_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic [DATA_WIDTH-1:0] noise_q, noise_d;
  logic [1:0]            width_q, width_d;
  logic                  pending_q, pending_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [1:0]            nerr_q, nerr_d;

  logic                  wr;
  logic [31:0]           cw_enc;
  logic [31:0]           rx;
  dec_t                  dec;
  logic [31:0]           result_data;
  logic [1:0]            result_err;

  always_comb begin
    cw_enc = encode_w(data_in_q[25:0], width_q);
    rx     = (op_q == OP_FULL) ? (cw_enc ^ noise_q[31:0]) : data_in_q[31:0];
    dec    = decode_w(rx, width_q);
    if (op_q == OP_ENCODE) begin
      result_data = cw_enc;
      result_err  = 2'd0;
    end else begin
      result_data = {6'd0, dec.data};
      result_err  = dec.nerr;
    end
  end

  always_comb begin
    wr         = PSEL && PENABLE && PWRITE;
    ctrl_d     = ctrl_q;
    data_in_d  = data_in_q;
    width_d    = width_q;
    noise_d    = noise_q;
    op_d       = op_q;
    pending_d  = 1'b0;
    done_d     = pending_q;
    data_out_d = data_out_q;
    nerr_d     = nerr_q;
    if (wr) begin
      case (PADDR)
        A_CTRL: begin
          ctrl_d = op_e'(PWDATA[1:0]);
          if (op_e'(PWDATA[1:0]) != OP_NOP) begin
            pending_d = 1'b1;
            op_d      = op_e'(PWDATA[1:0]);
          end
        end
        A_DATA:  data_in_d = DATA_WIDTH'(PWDATA);
        A_WIDTH: width_d   = PWDATA[1:0];
        A_NOISE: noise_d   = DATA_WIDTH'(PWDATA);
        default: ;
      endcase
    end
    if (pending_q) begin
      data_out_d = DATA_WIDTH'(result_data);
      nerr_d     = result_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q     <= OP_ENCODE;
      op_q       <= OP_ENCODE;
      data_in_q  <= '0;
      noise_q    <= '0;
      width_q    <= '0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      nerr_q     <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      op_q       <= op_d;
      data_in_q  <= data_in_d;
      noise_q    <= noise_d;
      width_q    <= width_d;
      pending_q  <= pending_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      nerr_q     <= nerr_d;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        A_CTRL:  PRDATA = AMBA_WORD'(ctrl_q);
        A_DATA:  PRDATA = AMBA_WORD'(data_in_q);
        A_WIDTH: PRDATA = AMBA_WORD'(width_q);
        A_NOISE: PRDATA = AMBA_WORD'(noise_q);
        default: PRDATA = '0;
      endcase
    end
  end

  assign data_out       = data_out_q;
  assign operation_done = done_q;
  assign num_of_errors  = nerr_q;

endmodule

// File: tb/tb_ecc_enc_dec.sv
// Bench for ecc_enc_dec: directed APB stimulus, a nearest-codeword reference model,
// a per-cycle output comparator and hand-computed literal expectations.
module tb_ecc_enc_dec;
  localparam int AW  = 32;
  localparam int ADW = 20;
  localparam int DW  = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [ADW-1:0] PADDR = '0;
  logic           PENABLE = 1'b0;
  logic           PSEL = 1'b0;
  logic [AW-1:0]  PWDATA = '0;
  logic           PWRITE = 1'b0;
  logic [AW-1:0]  PRDATA;
  logic [DW-1:0]  data_out;
  logic           operation_done;
  logic [1:0]     num_of_errors;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  ecc_enc_dec #(
    .AMBA_WORD(AW),
    .AMBA_ADDR_WIDTH(ADW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .PADDR(PADDR),
    .PENABLE(PENABLE),
    .PSEL(PSEL),
    .PWDATA(PWDATA),
    .PWRITE(PWRITE),
    .PRDATA(PRDATA),
    .data_out(data_out),
    .operation_done(operation_done),
    .num_of_errors(num_of_errors)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: codewords built from the parity definition, decoding by distance search.
  function automatic int m_n(input logic [1:0] w);
    return (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
  endfunction

  function automatic logic [31:0] m_mask(input int n);
    return (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic [31:0] m_encode(input logic [31:0] d, input int n);
    int          k;
    int          cnt;
    int          hh[26];
    logic [31:0] p;
    logic [31:0] cw;
    k   = (n == 8) ? 4 : (n == 16) ? 11 : 26;
    cnt = 0;
    for (int v = 3; cnt < k; v++) begin
      if ((v & (v - 1)) != 0) begin
        hh[cnt] = v;
        cnt++;
      end
    end
    p = '0;
    for (int i = 0; i < k; i++) if (d[i]) p = p ^ 32'(hh[i]);
    cw = (d & ((32'd1 << k) - 32'd1)) | (p << k);
    if (($countones(cw) % 2) == 1) cw = cw | (32'd1 << (n - 1));
    return cw;
  endfunction

  function automatic bit m_valid(input logic [31:0] r, input int n);
    return m_encode(r, n) == (r & m_mask(n));
  endfunction

  task automatic m_decode(input logic [31:0] r_in, input int n,
                          output logic [31:0] data, output logic [1:0] err);
    int          k;
    logic [31:0] r;
    logic [31:0] kmask;
    k     = (n == 8) ? 4 : (n == 16) ? 11 : 26;
    kmask = (32'd1 << k) - 32'd1;
    r     = r_in & m_mask(n);
    data  = r & kmask;
    err   = 2'd2;
    if (m_valid(r, n)) begin
      err = 2'd0;
    end else begin
      for (int b = 0; b < n; b++) begin
        if (err == 2'd2 && m_valid(r ^ (32'd1 << b), n)) begin
          data = (r ^ (32'd1 << b)) & kmask;
          err  = 2'd1;
        end
      end
    end
  endtask

  logic [1:0]  m_ctrl = '0, m_op = '0, m_width = '0, m_err = '0;
  logic [31:0] m_din = '0, m_noise = '0, m_data = '0;
  bit          m_pend = 1'b0, m_done = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ctrl = '0; m_op = '0; m_width = '0; m_err = '0;
      m_din = '0; m_noise = '0; m_data = '0;
      m_pend = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_pend) begin
        case (m_op)
          2'd0: begin
            m_data = m_encode(m_din, m_n(m_width));
            m_err  = 2'd0;
          end
          2'd1:    m_decode(m_din, m_n(m_width), m_data, m_err);
          default: m_decode(m_encode(m_din, m_n(m_width)) ^ m_noise, m_n(m_width), m_data, m_err);
        endcase
        m_done = 1'b1;
      end
      m_pend = 1'b0;
      if (PSEL && PENABLE && PWRITE) begin
        case (PADDR)
          20'h0: begin
            m_ctrl = PWDATA[1:0];
            if (PWDATA[1:0] != 2'd3) begin
              m_pend = 1'b1;
              m_op   = PWDATA[1:0];
            end
          end
          20'h4:   m_din   = PWDATA;
          20'h8:   m_width = PWDATA[1:0];
          20'hC:   m_noise = PWDATA;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_data_out", data_out, m_data);
      check("cyc_num_of_errors", 32'(num_of_errors), 32'(m_err));
      check("cyc_operation_done", 32'(operation_done), 32'(m_done));
    end
  end

  task automatic apb_write(input logic [19:0] addr, input logic [31:0] data);
    @(posedge clk); #2;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    @(posedge clk); #2;
    PENABLE = 1'b1;
    @(posedge clk); #2;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input string name, input logic [19:0] addr, input logic [31:0] exp);
    @(posedge clk); #2;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
    #1 check(name, PRDATA, exp);
    @(posedge clk); #2;
    PENABLE = 1'b1;
    @(posedge clk); #2;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (operation_done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: got no operation_done pulse expected one", name);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] w, input logic [31:0] din,
                        input logic [31:0] noise, input logic [1:0] op);
    apb_write(20'h8, {30'd0, w});
    apb_write(20'h4, din);
    apb_write(20'hC, noise);
    apb_write(20'h0, {30'd0, op});
    wait_done(name);
  endtask

  task automatic expect_out(input string name, input logic [31:0] d, input logic [1:0] e);
    check({name, "_data"}, data_out, d);
    check({name, "_err"}, 32'(num_of_errors), 32'(e));
  endtask

  initial begin
    int          n;
    int          p1;
    int          p2;
    logic [31:0] nz;
    logic [31:0] rnd;

    check("model_enc8", m_encode(32'hA, 8), 32'hAA);
    check("model_enc16", m_encode(32'h1, 16), 32'h9801);

    #1 rst = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    expect_out("reset", 32'h0, 2'd0);
    check("reset_done", 32'(operation_done), 32'h0);
    apb_read("rd_ctrl_rst", 20'h0, 32'h0);
    apb_read("rd_data_rst", 20'h4, 32'h0);
    apb_read("rd_width_rst", 20'h8, 32'h0);
    apb_read("rd_noise_rst", 20'hC, 32'h0);

    apb_write(20'hC, 32'h20);
    apb_read("rd_noise", 20'hC, 32'h20);
    apb_read("rd_unmapped", 20'h10, 32'h0);
    apb_write(20'h10, 32'hFFFF_FFFF);
    apb_read("rd_unmapped_wr", 20'h10, 32'h0);

    run_op("enc8", 2'd0, 32'hA, 32'h0, 2'd0);
    expect_out("enc8", 32'hAA, 2'd0);
    @(negedge clk);
    check("enc8_pulse_width", 32'(operation_done), 32'h0);

    run_op("dec8_clean", 2'd0, 32'hAA, 32'h0, 2'd1);
    expect_out("dec8_clean", 32'hA, 2'd0);
    run_op("dec8_single", 2'd0, 32'hAB, 32'h0, 2'd1);
    expect_out("dec8_single", 32'hA, 2'd1);

    run_op("full8_par", 2'd0, 32'hA, 32'h20, 2'd2);
    expect_out("full8_par", 32'hA, 2'd1);
    run_op("full8_data", 2'd0, 32'hA, 32'h01, 2'd2);
    expect_out("full8_data", 32'hA, 2'd1);
    run_op("full8_double", 2'd0, 32'hA, 32'h03, 2'd2);
    expect_out("full8_double", 32'h9, 2'd2);
    run_op("full8_overall", 2'd0, 32'hA, 32'h80, 2'd2);
    expect_out("full8_overall", 32'hA, 2'd1);
    apb_read("rd_ctrl", 20'h0, 32'h2);

    apb_write(20'h0, 32'h3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nop_no_pulse", 32'(operation_done), 32'h0);
    end
    expect_out("nop_hold", 32'hA, 2'd1);
    apb_read("rd_ctrl_nop", 20'h0, 32'h3);

    run_op("enc16", 2'd1, 32'h1, 32'h0, 2'd0);
    expect_out("enc16", 32'h9801, 2'd0);
    run_op("enc32", 2'd2, 32'h1, 32'h0, 2'd0);
    expect_out("enc32", 32'h8C00_0001, 2'd0);
    run_op("enc32_w3", 2'd3, 32'h1, 32'h0, 2'd0);
    expect_out("enc32_w3", 32'h8C00_0001, 2'd0);
    run_op("dec32_msb", 2'd2, 32'h0C00_0001, 32'h0, 2'd1);
    expect_out("dec32_msb", 32'h1, 2'd1);

    for (int w = 0; w < 3; w++) begin
      n = m_n(w[1:0]);
      for (int i = 0; i < 6; i++) begin
        rnd = $urandom;
        p1  = $urandom_range(0, n - 1);
        p2  = (p1 + 1 + $urandom_range(0, n - 2)) % n;
        nz  = '0;
        if (i % 3 >= 1) nz[p1] = 1'b1;
        if (i % 3 == 2) nz[p2] = 1'b1;
        run_op("rand_full", w[1:0], rnd, nz, 2'd2);
        run_op("rand_dec", w[1:0], rnd, 32'h0, 2'd1);
        run_op("rand_enc", w[1:0], rnd, 32'h0, 2'd0);
      end
    end

    apb_write(20'h8, 32'h0);
    apb_write(20'h4, 32'h5);
    apb_write(20'h0, 32'h0);
    apb_write(20'h0, 32'h1);
    wait_done("back_to_back");
    repeat (2) @(negedge clk);

    apb_write(20'h4, 32'hA);
    apb_write(20'h0, 32'h0);
    rst = 1'b0;
    #1 expect_out("rst_mid", 32'h0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_pulse", 32'(operation_done), 32'h0);
    end
    @(posedge clk); #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_after", 32'(operation_done), 32'h0);
    apb_read("rd_data_after_rst", 20'h4, 32'h0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
